// File: rtl/alu_pipe_if.sv
// Handshaked operand/result bundle for alu_pipe: valid/ready operand port,
// valid/ready result port with flags, and the sticky-overflow controls.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             car;
  logic             of;
  logic             zero;
  logic             neg;
  logic             err;

  logic             clr_sticky;
  logic             sticky_of;

  // Front end / display side: offers operands, takes results.
  modport master (
    output in_valid, a, b, op, out_ready, clr_sticky,
    input  in_ready, out_valid, res, car, of, zero, neg, err, sticky_of
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, op, out_ready, clr_sticky,
    output in_ready, out_valid, res, car, of, zero, neg, err, sticky_of
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: eight single-cycle ops plus an iterative unsigned shift-add
// multiply, with a held result register and a sticky overflow flag.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]         state;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNTW-1:0]    cnt;

  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               car_q;
  logic               of_q;
  logic               zero_q;
  logic               neg_q;
  logic               err_q;
  logic               sticky_q;

  logic               accept;
  logic               deliver;
  logic               start_mul;
  logic               mul_done;
  logic               load;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               slt;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_car;
  logic               sc_of;
  logic               sc_err;

  logic [WIDTH-1:0]   nxt_res;
  logic               nxt_car;
  logic               nxt_of;
  logic               nxt_err;

  // Ready only looks at our own state, never at in_valid, so no comb loop
  // can form through the producer.
  assign bus.in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready);

  assign accept    = bus.in_valid && bus.in_ready;
  assign deliver   = out_valid_q && bus.out_ready;
  assign start_mul = accept && (bus.op == OP_MULU);
  assign mul_done  = (state == S_MUL) && (cnt == CNTW'(WIDTH - 1));
  assign load      = mul_done || (accept && !start_mul);

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
  assign slt  = $signed(bus.a) < $signed(bus.b);

  always_comb begin
    // NOTE: every output of this block gets a default first so that no op
    // code path can leave one unassigned and infer a latch.
    sc_res = '0;
    sc_car = 1'b0;
    sc_of  = 1'b0;
    sc_err = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_car = sum[WIDTH];
        sc_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_car = diff[WIDTH];
        sc_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT:  sc_res = ~bus.a;
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_MULU: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // A finishing multiply and a single-cycle accept are mutually exclusive:
  // in_ready is low for the whole of S_MUL.
  assign nxt_res = mul_done ? acc_nxt[WIDTH-1:0] : sc_res;
  assign nxt_of  = mul_done ? |acc_nxt[2*WIDTH-1:WIDTH] : sc_of;
  assign nxt_car = mul_done ? 1'b0 : sc_car;
  assign nxt_err = mul_done ? 1'b0 : sc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: multiplier datapath and counter are reset along with the FSM so
    // an aborted multiply leaves nothing behind to complete later.
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic so every
      // register samples the pre-edge values of its neighbours.
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            state  <= S_MUL;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNTW'(1);
          if (mul_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      car_q       <= 1'b0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      res_q       <= nxt_res;
      car_q       <= nxt_car;
      of_q        <= nxt_of;
      zero_q      <= (nxt_res == '0);
      neg_q       <= nxt_res[WIDTH-1];
      err_q       <= nxt_err;
    end else if (deliver) begin
      out_valid_q <= 1'b0;
    end
  end

  // Setting wins over a same-edge clear so no overflow event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (load && nxt_of) begin
      sticky_q <= 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.car       = car_q;
  assign bus.of        = of_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
  assign bus.sticky_of = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): vector table for the single-cycle
// ops, plus hand sequences for multiply, backpressure, sticky and reset abort.
module tb_alu_pipe;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         car;
    logic         of;
    logic         zero;
    logic         neg;
    logic         err;
  } vec_t;

  vec_t vecs [15];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {res, car, of, zero, neg, err}
  function automatic logic [31:0] outs();
    return {19'd0, bus.res, bus.car, bus.of, bus.zero, bus.neg, bus.err};
  endfunction

  function automatic logic [31:0] pack(input logic [W-1:0] r, input logic c, input logic o,
                                       input logic z, input logic n, input logic e);
    return {19'd0, r, c, o, z, n, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [31:0] exp);
    present(4'd8, a, b);
    check({name, " in_ready@accept"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      check($sformatf("%s in_ready busy %0d", name, i), 32'(bus.in_ready), 32'd0);
      check($sformatf("%s out_valid busy %0d", name, i), 32'(bus.out_valid), 32'd0);
      step();
    end
    check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, " result"}, outs(), exp);
    check({name, " in_ready after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //               op     a      b      res    car   of    zero  neg   err
    vecs[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd6,  8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd6,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'd7,  8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd12, 8'h33, 8'h44, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd2,  8'h0F, 8'hAA, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd4,  8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{4'd5,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd7,  8'h12, 8'h13, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd1,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'd0,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.op         = '0;
    bus.out_ready  = 1'b1;
    bus.clr_sticky = 1'b0;

    // Reset state
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset outputs", outs(), 32'd0);
    check("reset sticky", 32'(bus.sticky_of), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Sticky overflow: set, clear, and set-wins-over-clear
    present(4'd0, 8'h7F, 8'h01);
    step();
    bus.in_valid = 1'b0;
    check("sticky set", 32'(bus.sticky_of), 32'd1);
    bus.clr_sticky = 1'b1;
    step();
    check("sticky cleared", 32'(bus.sticky_of), 32'd0);
    check("drained out_valid", 32'(bus.out_valid), 32'd0);
    present(4'd0, 8'h7F, 8'h01);
    step();
    bus.in_valid = 1'b0;
    check("sticky set wins", 32'(bus.sticky_of), 32'd1);
    step();
    check("sticky cleared again", 32'(bus.sticky_of), 32'd0);
    bus.clr_sticky = 1'b0;

    // Single-cycle table, back to back at full throughput
    for (int i = 0; i < 15; i++) begin
      present(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      step();
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d result", i), outs(),
            pack(vecs[i].res, vecs[i].car, vecs[i].of, vecs[i].zero, vecs[i].neg, vecs[i].err));
    end
    bus.in_valid = 1'b0;
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    check("table drained", 32'(bus.out_valid), 32'd0);
    check("table sticky cleared", 32'(bus.sticky_of), 32'd0);

    // Multiply
    run_mul("mul10x10", 8'h10, 8'h10, pack(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    check("mul sticky", 32'(bus.sticky_of), 32'd1);
    run_mul("mul0Fx11", 8'h0F, 8'h11, pack(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run_mul("mulFFxFF", 8'hFF, 8'hFF, pack(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    check("mul drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: three ops offered, only the first is taken while stalled
    bus.out_ready = 1'b0;
    present(4'd0, 8'h01, 8'h02);
    step();
    check("bp first result", outs(), pack(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    present(4'd5, 8'hAA, 8'h55);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp stall in_ready %0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp stall res %0d", i), outs(), pack(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    bus.out_ready = 1'b1;
    step();
    check("bp second result", outs(), pack(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    present(4'd3, 8'hF0, 8'h3C);
    step();
    check("bp third result", outs(), pack(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    check("bp third valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("bp drained", 32'(bus.out_valid), 32'd0);

    // Make sticky and res nonzero so the abort visibly clears them
    run_mul("mulFFxFF pre-abort", 8'hFF, 8'hFF, pack(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Reset three cycles into a multiply
    present(4'd8, 8'h0F, 8'h11);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort outputs", outs(), 32'd0);
    check("abort sticky", 32'(bus.sticky_of), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    repeat (10) step();
    check("abort no stray out_valid", 32'(bus.out_valid), 32'd0);
    present(4'd0, 8'h22, 8'h11);
    step();
    bus.in_valid = 1'b0;
    check("post-abort add valid", 32'(bus.out_valid), 32'd1);
    check("post-abort add", outs(), pack(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
